lifo_stack: RTL and testbench

- Synchronous last-in/first-out stack of DEPTH words, each WL bits wide.
- Single clock domain, with one write port (push) and one read port (pop).
- Provides registered read data plus Full, Empty and Error status.
- Used as a generic buffering primitive in the memory library, for example return-address or operand stacks.

---
 rtl/lifo_stack_pkg.sv | 33 +++
 rtl/lifo_stack_mem.sv | 25 ++
 rtl/lifo_stack.sv | 70 +++++++
 tb/tb_lifo_stack.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lifo_stack_pkg.sv
// Shared request decoding for the LIFO stack: classifies each sampled
// push/pop request pair into one operation.
package lifo_stack_pkg;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_OVERFLOW,
        OP_UNDERFLOW,
        OP_CONFLICT
    } stack_op_e;

    // A push and a pop in the same cycle are rejected outright rather than
    // being merged into a replace-top operation.
    function automatic stack_op_e decode_op(input logic rd, input logic wr,
                                            input logic full, input logic empty);
        stack_op_e op;
        op = OP_IDLE;
        if (rd && wr)
            op = OP_CONFLICT;
        else if (wr)
            op = full ? OP_OVERFLOW : OP_PUSH;
        else if (rd)
            op = empty ? OP_UNDERFLOW : OP_POP;
        return op;
    endfunction

    function automatic logic is_illegal(input stack_op_e op);
        return (op == OP_OVERFLOW) || (op == OP_UNDERFLOW) || (op == OP_CONFLICT);
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// DEPTH x WL register file with one synchronous write port and one
// asynchronous read port; contents are never reset.
module lifo_stack_mem #(
    parameter int WL    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WL-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WL-1:0] rdata
);

    logic [WL-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack top level: stack pointer, request decode, registered pop data
// and a one-cycle Error flag for rejected requests.
module lifo_stack #(
    parameter int WL    = 8,
    parameter int DEPTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          rReq,
    input  logic          wReq,
    input  logic [WL-1:0] din,
    output logic          Full,
    output logic          Empty,
    output logic          Error,
    output logic [WL-1:0] dout
);

    import lifo_stack_pkg::*;

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0] sp;
    logic [WL-1:0] topData;
    stack_op_e     op;
    logic          memWe;

    assign Full  = (sp == PW'(DEPTH));
    assign Empty = (sp == '0);

    always_comb begin
        op = decode_op(rReq, wReq, Full, Empty);
    end

    // Reset must also suppress the write so a push coinciding with reset
    // leaves no trace.
    assign memWe = (op == OP_PUSH) && !RST;

    lifo_stack_mem #(
        .WL   (WL),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .CLK  (CLK),
        .we   (memWe),
        .waddr(AW'(sp)),
        .wdata(din),
        .raddr(AW'(sp - PW'(1))),
        .rdata(topData)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            sp    <= '0;
            dout  <= '0;
            Error <= 1'b0;
        end else begin
            Error <= is_illegal(op);
            case (op)
                OP_PUSH: sp <= sp + PW'(1);
                OP_POP: begin
                    sp   <= sp - PW'(1);
                    dout <= topData;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard-based bench for lifo_stack: a queue models the stack and popped
// values are queued as expectations, then compared against dout.
module tb_lifo_stack;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rReq = 1'b0;
    logic       wReq = 1'b0;
    logic [7:0] din = '0;
    logic       Full;
    logic       Empty;
    logic       Error;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] stk[$];
    logic [7:0] expQ[$];
    logic [7:0] expDout = '0;
    logic       expErr = 1'b0;
    logic       popped = 1'b0;
    logic [7:0] want;

    lifo_stack #(.WL(8), .DEPTH(8)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .rReq (rReq),
        .wReq (wReq),
        .din  (din),
        .Full (Full),
        .Empty(Empty),
        .Error(Error),
        .dout (dout)
    );

    always #5 CLK = ~CLK;

    // Drives one edge worth of requests and advances the reference model.
    task automatic applyStimulus(input logic r, input logic w, input logic [7:0] d,
                                 input logic rst = 1'b0);
        logic [7:0] v;
        RST = rst; rReq = r; wReq = w; din = d;
        popped = 1'b0;
        if (rst) begin
            stk.delete();
            expDout = '0;
            expErr  = 1'b0;
        end else if (r && w) begin
            expErr = 1'b1;
        end else if (w) begin
            if (stk.size() == 8) expErr = 1'b1;
            else begin stk.push_back(d); expErr = 1'b0; end
        end else if (r) begin
            if (stk.size() == 0) expErr = 1'b1;
            else begin
                v = stk.pop_back();
                expQ.push_back(v);
                expDout = v;
                expErr  = 1'b0;
                popped  = 1'b1;
            end
        end else begin
            expErr = 1'b0;
        end
        @(posedge CLK);
        #1;
        RST = 1'b0; rReq = 1'b0; wReq = 1'b0;
    endtask

    task automatic test_reset;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (Empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got=%0b exp=1", Empty); end
        checks++; if (Full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%0b exp=0", Full); end
        checks++; if (Error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got=%0b exp=0", Error); end
        checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout got=%h exp=00", dout); end
        applyStimulus(1'b1, 1'b0, 8'h00);
        checks++; if (Error !== 1'b1) begin errors++; $display("[TB] FAIL underflow_error got=%0b exp=1", Error); end
        checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL underflow_dout got=%h exp=00", dout); end
        checks++; if (Empty !== 1'b1) begin errors++; $display("[TB] FAIL underflow_empty got=%0b exp=1", Empty); end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checks++; if (Error !== 1'b0) begin errors++; $display("[TB] FAIL underflow_clear got=%0b exp=0", Error); end
    endtask

    task automatic test_push_pop;
        logic [7:0] vals[6] = '{8'd1, 8'd2, 8'd4, 8'd5, 8'd7, 8'd4};
        foreach (vals[i]) begin
            applyStimulus(1'b0, 1'b1, vals[i]);
            checks++; if (Error !== 1'b0) begin errors++; $display("[TB] FAIL push_error[%0d] got=%0b exp=0", i, Error); end
        end
        checks++; if (Empty !== 1'b0) begin errors++; $display("[TB] FAIL push_empty got=%0b exp=0", Empty); end
        applyStimulus(1'b1, 1'b0, 8'h00);
        want = expQ.pop_front();
        checks++; if (dout !== want) begin errors++; $display("[TB] FAIL pop_dout got=%0d exp=%0d", dout, want); end
        checks++; if (dout !== 8'd4) begin errors++; $display("[TB] FAIL pop_first got=%0d exp=4", dout); end
        checks++; if (Full !== 1'b0 || Empty !== 1'b0) begin errors++; $display("[TB] FAIL pop_flags full=%0b empty=%0b exp=0/0", Full, Empty); end
        applyStimulus(1'b0, 1'b1, 8'd3);
        applyStimulus(1'b0, 1'b1, 8'd1);
        checks++; if (Full !== 1'b0) begin errors++; $display("[TB] FAIL seven_full got=%0b exp=0", Full); end
    endtask

    task automatic test_drain;
        logic [7:0] seq[6] = '{8'd1, 8'd3, 8'd7, 8'd5, 8'd4, 8'd2};
        foreach (seq[i]) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            want = expQ.pop_front();
            checks++; if (dout !== want || dout !== seq[i]) begin errors++; $display("[TB] FAIL drain_dout[%0d] got=%0d exp=%0d", i, dout, seq[i]); end
        end
        checks++; if (Empty !== 1'b0) begin errors++; $display("[TB] FAIL drain_one_left got=%0b exp=0", Empty); end
        applyStimulus(1'b0, 1'b1, 8'd2);
        applyStimulus(1'b1, 1'b0, 8'h00);
        want = expQ.pop_front();
        checks++; if (dout !== want) begin errors++; $display("[TB] FAIL drain_pop2 got=%0d exp=%0d", dout, want); end
        applyStimulus(1'b1, 1'b0, 8'h00);
        want = expQ.pop_front();
        checks++; if (dout !== want) begin errors++; $display("[TB] FAIL drain_pop1 got=%0d exp=%0d", dout, want); end
        checks++; if (Empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty got=%0b exp=1", Empty); end
    endtask

    task automatic test_full;
        for (int i = 0; i < 8; i++) begin
            checks++; if (Full !== 1'b0) begin errors++; $display("[TB] FAIL fill_early_full[%0d] got=%0b exp=0", i, Full); end
            applyStimulus(1'b0, 1'b1, 8'(8'h10 + i));
        end
        checks++; if (Full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got=%0b exp=1", Full); end
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checks++; if (Error !== expErr || Error !== 1'b1) begin errors++; $display("[TB] FAIL overflow_error got=%0b exp=1", Error); end
        checks++; if (Full !== 1'b1) begin errors++; $display("[TB] FAIL overflow_full got=%0b exp=1", Full); end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            want = expQ.pop_front();
            checks++; if (dout !== want || Error !== 1'b0) begin errors++; $display("[TB] FAIL unload[%0d] dout=%h err=%0b exp=%h/0", i, dout, Error, want); end
        end
        checks++; if (Empty !== 1'b1) begin errors++; $display("[TB] FAIL unload_empty got=%0b exp=1", Empty); end
    endtask

    task automatic test_simultaneous;
        applyStimulus(1'b0, 1'b1, 8'hA1);
        applyStimulus(1'b0, 1'b1, 8'hA2);
        applyStimulus(1'b0, 1'b1, 8'hA3);
        applyStimulus(1'b1, 1'b1, 8'h55);
        checks++; if (Error !== 1'b1) begin errors++; $display("[TB] FAIL both_error got=%0b exp=1", Error); end
        checks++; if (dout !== expDout) begin errors++; $display("[TB] FAIL both_dout got=%h exp=%h", dout, expDout); end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checks++; if (Error !== 1'b0) begin errors++; $display("[TB] FAIL both_clear got=%0b exp=0", Error); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            want = expQ.pop_front();
            checks++; if (dout !== want) begin errors++; $display("[TB] FAIL both_pop[%0d] got=%h exp=%h", i, dout, want); end
        end
        checks++; if (Empty !== 1'b1) begin errors++; $display("[TB] FAIL both_count got=%0b exp=1", Empty); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h30 + i));
        applyStimulus(1'b1, 1'b0, 8'h00);
        want = expQ.pop_front();
        checks++; if (dout !== want) begin errors++; $display("[TB] FAIL mid_pop got=%h exp=%h", dout, want); end
        applyStimulus(1'b0, 1'b1, 8'h99, 1'b1);
        checks++; if (Empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_empty got=%0b exp=1", Empty); end
        checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL mid_dout got=%h exp=00", dout); end
        checks++; if (Error !== 1'b0) begin errors++; $display("[TB] FAIL mid_error got=%0b exp=0", Error); end
        applyStimulus(1'b1, 1'b0, 8'h00);
        checks++; if (Error !== 1'b1 || dout !== 8'h00) begin errors++; $display("[TB] FAIL mid_ignored err=%0b dout=%h exp=1/00", Error, dout); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_drain();
        test_full();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
